// File: rtl/msrv32_ahb_pkg.sv
// Shared types for the msrv32 AHB-Lite data-side slave.
//   htrans_e      : AHB HTRANS encodings
//   HRESP_*       : HRESP encodings
//   slave_state_e : data-phase response FSM states
//   lane_bits()   : log2 of the byte-lane count for a given bus width
package msrv32_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_WAIT  = 2'd1,
        S_ERR1  = 2'd2,
        S_ERR2  = 2'd3
    } slave_state_e;

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/msrv32_bytemask_ram.sv
// DEPTH x DATA_W word memory, per-byte write enables, registered read.
// Contents are never reset. A read and write to the same word on the same
// edge returns the old contents; the caller handles forwarding.
//   clk_i   : clock
//   we_i    : per-byte write enable (bit i -> byte i)
//   waddr_i : write word index
//   wdata_i : write data
//   re_i    : read enable; rdata_o holds its last value when low
//   raddr_i : read word index
//   rdata_o : registered read data
module msrv32_bytemask_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int BL    = DATA_W / 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [BL-1:0]     we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [BL-1:0][7:0] mem [DEPTH];
    logic [DATA_W-1:0]  rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BL; b++) begin
            if (we_i[b]) mem[waddr_i][b] <= wdata_i[b*8 +: 8];
        end
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/msrv32_ahb_data_slave.sv
// AHB-Lite data-side slave for the msrv32 core: word memory with byte-masked
// writes, WAIT_STATES hready-low cycles per OKAY transfer, two-cycle ERROR
// responses for misaligned or out-of-range addresses, saturating error count.
//   ms_riscv32_mp_clk_in / _rst_in     : clock, synchronous active-high reset
//   ms_riscv32_mp_dmaddr_out           : address-phase byte address
//   ms_riscv32_mp_dmdata_out           : data-phase write data
//   ms_riscv32_mp_dmwr_mask_out        : address-phase byte write mask
//   ms_riscv32_mp_dmwr_req_out         : address-phase write(1)/read(0)
//   ms_riscv32_mp_data_htrans_out      : HTRANS
//   ms_riscv32_mp_data_in              : HRDATA
//   ms_riscv32_mp_data_hready_in       : HREADY
//   ms_riscv32_mp_hresp_in             : HRESP (1 = ERROR)
//   ms_riscv32_mp_err_count_out        : saturating ERROR response count
module msrv32_ahb_data_slave
    import msrv32_ahb_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 32,
    parameter int              DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              WAIT_STATES = 0,
    localparam int             BL          = DATA_W / 8
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out,
    input  logic [DATA_W-1:0] ms_riscv32_mp_dmdata_out,
    input  logic [BL-1:0]     ms_riscv32_mp_dmwr_mask_out,
    input  logic              ms_riscv32_mp_dmwr_req_out,
    input  logic [1:0]        ms_riscv32_mp_data_htrans_out,
    output logic [DATA_W-1:0] ms_riscv32_mp_data_in,
    output logic              ms_riscv32_mp_data_hready_in,
    output logic              ms_riscv32_mp_hresp_in,
    output logic [15:0]       ms_riscv32_mp_err_count_out
);

    localparam int LB = lane_bits(DATA_W);
    localparam int IW = $clog2(DEPTH);

    logic clk, rst;
    assign clk = ms_riscv32_mp_clk_in;
    assign rst = ms_riscv32_mp_rst_in;

    slave_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;

    // Data-phase bookkeeping captured at address-phase accept.
    logic          dp_vld_q, dp_ok_q, dp_wr_q;
    logic [BL-1:0] dp_mask_q;
    logic [IW-1:0] dp_idx_q;

    // Read-return shaping: forced zero after ERROR/reset, per-lane forwarding
    // of a write that completed on the same edge the read was accepted.
    logic              zero_q;
    logic [BL-1:0]     byp_mask_q;
    logic [DATA_W-1:0] byp_data_q;
    logic [15:0]       err_cnt_q;

    htrans_e           htrans;
    logic              hready, accept, dec_ok, complete, wr_fire, rd_fire, raw_hit;
    logic [ADDR_W-1:0] off;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] ram_rdata;

    assign htrans = htrans_e'(ms_riscv32_mp_data_htrans_out);
    assign hready = (state_q == S_READY) || (state_q == S_ERR2);
    assign accept = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign off    = ms_riscv32_mp_dmaddr_out - BASE_ADDR;
    assign dec_ok = ((off >> LB) < ADDR_W'(DEPTH)) && (off[LB-1:0] == '0);
    assign idx    = off[LB +: IW];

    assign complete = hready && dp_vld_q;
    assign wr_fire  = complete && dp_ok_q && dp_wr_q && !rst;
    assign rd_fire  = accept && dec_ok && !ms_riscv32_mp_dmwr_req_out && !rst;
    assign raw_hit  = wr_fire && (dp_idx_q == idx);

    msrv32_bytemask_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_fire ? dp_mask_q : '0),
        .waddr_i (dp_idx_q),
        .wdata_i (ms_riscv32_mp_dmdata_out),
        .re_i    (rd_fire),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_READY, S_ERR2: begin
                state_d = S_READY;
                if (accept) begin
                    if (!dec_ok) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_READY;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_READY;
            cnt_q      <= '0;
            dp_vld_q   <= 1'b0;
            dp_ok_q    <= 1'b0;
            dp_wr_q    <= 1'b0;
            dp_mask_q  <= '0;
            dp_idx_q   <= '0;
            zero_q     <= 1'b1;
            byp_mask_q <= '0;
            byp_data_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // A pending data phase retires on the first hready-high edge.
            if (hready) dp_vld_q <= accept;
            if (accept) begin
                dp_ok_q   <= dec_ok;
                dp_wr_q   <= ms_riscv32_mp_dmwr_req_out;
                dp_mask_q <= ms_riscv32_mp_dmwr_mask_out;
                dp_idx_q  <= idx;
                if (!dec_ok) begin
                    zero_q <= 1'b1;
                    if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
            if (rd_fire) begin
                zero_q     <= 1'b0;
                byp_mask_q <= raw_hit ? dp_mask_q : '0;
                byp_data_q <= ms_riscv32_mp_dmdata_out;
            end
        end
    end

    always_comb begin
        ms_riscv32_mp_data_in = '0;
        for (int b = 0; b < BL; b++) begin
            if (!zero_q)
                ms_riscv32_mp_data_in[b*8 +: 8] = byp_mask_q[b] ? byp_data_q[b*8 +: 8]
                                                                : ram_rdata[b*8 +: 8];
        end
    end

    assign ms_riscv32_mp_data_hready_in = hready;
    assign ms_riscv32_mp_hresp_in       = (state_q == S_ERR1 || state_q == S_ERR2) ?
                                          HRESP_ERROR : HRESP_OKAY;
    assign ms_riscv32_mp_err_count_out  = err_cnt_q;

endmodule

// File: tb/tb_msrv32_ahb_data_slave.sv
// Directed bench: dut0 runs with zero wait states, dut3 with three. Both share
// the address/data buses; each has its own HTRANS so only one is active.
module tb_msrv32_ahb_data_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    logic        wr;
    logic [1:0]  ht0, ht3;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, resp0, resp3;
    logic [15:0] err0, err3;

    int n_cmp = 0;
    int n_err = 0;
    int nlow;

    always #5 clk = ~clk;

    msrv32_ahb_data_slave #(.WAIT_STATES(0)) u_dut0 (
        .ms_riscv32_mp_clk_in          (clk),
        .ms_riscv32_mp_rst_in          (rst),
        .ms_riscv32_mp_dmaddr_out      (addr),
        .ms_riscv32_mp_dmdata_out      (wdata),
        .ms_riscv32_mp_dmwr_mask_out   (mask),
        .ms_riscv32_mp_dmwr_req_out    (wr),
        .ms_riscv32_mp_data_htrans_out (ht0),
        .ms_riscv32_mp_data_in         (rd0),
        .ms_riscv32_mp_data_hready_in  (rdy0),
        .ms_riscv32_mp_hresp_in        (resp0),
        .ms_riscv32_mp_err_count_out   (err0)
    );

    msrv32_ahb_data_slave #(.WAIT_STATES(3)) u_dut3 (
        .ms_riscv32_mp_clk_in          (clk),
        .ms_riscv32_mp_rst_in          (rst),
        .ms_riscv32_mp_dmaddr_out      (addr),
        .ms_riscv32_mp_dmdata_out      (wdata),
        .ms_riscv32_mp_dmwr_mask_out   (mask),
        .ms_riscv32_mp_dmwr_req_out    (wr),
        .ms_riscv32_mp_data_htrans_out (ht3),
        .ms_riscv32_mp_data_in         (rd3),
        .ms_riscv32_mp_data_hready_in  (rdy3),
        .ms_riscv32_mp_hresp_in        (resp3),
        .ms_riscv32_mp_err_count_out   (err3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic aph(input logic [1:0] t0, input logic [1:0] t3, input logic [31:0] a,
                       input logic w, input logic [3:0] m);
        ht0  = t0;
        ht3  = t3;
        addr = a;
        wr   = w;
        mask = m;
    endtask

    // Counts hready-low samples on dut3, bounded.
    task automatic wait_rdy3(output int n);
        n = 0;
        while (rdy3 !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wdata = '0;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy0",  rdy0, 1);
        chk("rst_resp0", resp0, 0);
        chk("rst_data0", rd0, 0);
        chk("rst_err0",  err0, 0);
        chk("rst_rdy3",  rdy3, 1);

        // Full write then read of 0x100.
        aph(2'b10, 2'b00, 32'h100, 1'b1, 4'hF); tick();
        chk("w100_rdy", rdy0, 1);
        wdata = 32'hDEADBEEF;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0); tick();
        aph(2'b10, 2'b00, 32'h100, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("r100_rdy",  rdy0, 1);
        chk("r100_resp", resp0, 0);
        chk("r100_data", rd0, 32'hDEADBEEF);

        // Back-to-back writes with partial mask.
        aph(2'b10, 2'b00, 32'h104, 1'b1, 4'hF); tick();
        wdata = 32'h11223344;
        aph(2'b11, 2'b00, 32'h104, 1'b1, 4'b0101); tick();
        chk("b2b_rdy", rdy0, 1);
        wdata = 32'hAABBCCDD;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0); tick();
        aph(2'b10, 2'b00, 32'h104, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("r104_data", rd0, 32'h11BB33DD);

        // Known word at index 0 for the bad-write check.
        aph(2'b10, 2'b00, 32'h0, 1'b1, 4'hF); tick();
        wdata = 32'h12345678;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0); tick();

        // Misaligned read.
        aph(2'b10, 2'b00, 32'h102, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("mis_e1_rdy",  rdy0, 0);
        chk("mis_e1_resp", resp0, 1);
        chk("mis_err",     err0, 1);
        chk("mis_data",    rd0, 0);
        tick();
        chk("mis_e2_rdy",  rdy0, 1);
        chk("mis_e2_resp", resp0, 1);
        tick();
        chk("mis_done_resp", resp0, 0);

        // Out-of-range read at DEPTH*4.
        aph(2'b10, 2'b00, 32'h1000, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("oor_e1_rdy",  rdy0, 0);
        chk("oor_e1_resp", resp0, 1);
        chk("oor_err",     err0, 2);
        tick();
        chk("oor_e2_rdy",  rdy0, 1);
        chk("oor_e2_resp", resp0, 1);
        tick();

        // Out-of-range write must not alias onto index 0.
        aph(2'b10, 2'b00, 32'h1000, 1'b1, 4'hF); tick();
        wdata = 32'hFFFFFFFF;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("oorw_err", err0, 3);
        tick(); tick();
        aph(2'b10, 2'b00, 32'h0, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("oorw_nowrite", rd0, 32'h12345678);

        // RAW bypass: read accepted on the edge a partial write completes.
        aph(2'b10, 2'b00, 32'h300, 1'b1, 4'hF); tick();
        wdata = 32'h55555555;
        aph(2'b10, 2'b00, 32'h300, 1'b1, 4'b0011); tick();
        wdata = 32'hAAAA1234;
        aph(2'b10, 2'b00, 32'h300, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        chk("raw_data", rd0, 32'h55551234);
        tick();
        chk("raw_hold", rd0, 32'h55551234);

        // Wait states: write then read 0x200 on dut3.
        aph(2'b00, 2'b10, 32'h200, 1'b1, 4'hF); tick();
        wdata = 32'h0F0F1234;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        wait_rdy3(nlow);
        chk("ws_w_low", nlow, 3);
        tick();
        aph(2'b00, 2'b10, 32'h200, 1'b0, 4'h0); tick();
        chk("ws_r_resp", resp3, 0);
        wait_rdy3(nlow);          // NONSEQ held throughout the wait
        chk("ws_r_low",  nlow, 3);
        chk("ws_r_data", rd3, 32'h0F0F1234);
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0); tick();
        chk("ws_once_rdy", rdy3, 1);

        // Reset during the wait of a pending write to 0x400.
        aph(2'b00, 2'b10, 32'h400, 1'b1, 4'hF); tick();
        wdata = 32'h600DC0DE;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        wait_rdy3(nlow);
        tick();
        aph(2'b00, 2'b10, 32'h400, 1'b1, 4'hF); tick();
        wdata = 32'hBAD0BAD0;
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0); tick();
        chk("rw_inwait", rdy3, 0);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rw_rdy",  rdy3, 1);
        chk("rw_resp", resp3, 0);
        chk("rw_data", rd3, 0);
        tick(); tick(); tick(); tick();
        aph(2'b00, 2'b10, 32'h400, 1'b0, 4'h0); tick();
        aph(2'b00, 2'b00, 32'h0, 1'b0, 4'h0);
        wait_rdy3(nlow);
        chk("rw_low",  nlow, 3);
        chk("rw_old",  rd3, 32'h600DC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
